seg_scan_reader: RTL and testbench
==================================

# seg_scan_reader

Recovers hexadecimal digit values from a time-multiplexed, active-low 7-segment display bus; it is the reading end of the hex-to-segment encoding used on the display outputs. Watches segment and digit-select lines, qualifies each pattern for stability, decodes it back to a nibble and keeps a per-digit value register. Used for display loopback self-test and for capturing the display state of external boards.

## Interface
- DIGITS, 4, number of multiplexed digits (1..8)
- STABLE_CYC, 4, consecutive identical registered samples required before commit (>=1)
- IW, derived, max(1, clog2(DIGITS)); not user-set
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- seg_i  in  7  segments, active-low, bit0=a … bit6=g; synchronous to clk_i
- dig_i  in  DIGITS  digit selects, active-low, one-hot-low when valid
- val_o  out  4*DIGITS  committed nibble of digit k at [4k+3:4k]
- dig_valid_o  out  DIGITS  bit k set once digit k has a committed value
- upd_o  out  1  one-cycle pulse on each successful commit
- upd_idx_o  out  IW  digit index of last commit/error
- upd_val_o  out  4  nibble of last commit
- err_o  out  1  one-cycle pulse when a qualified pattern is not decodable
- err_cnt_o  out  8  saturating count of err_o pulses

## Operation
- Input stage: seg_i and dig_i registered once each cycle into p = {seg, dig}; all downstream logic uses p.
- Decode table (seg bits g..a, 0=lit): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. All other non-blank codes are invalid.
- Blank = 1111111: never commits, never errors.
- p is "eligible" when exactly one dig bit is 0 and seg is not blank.
- FSM states:
  - IDLE: p not eligible; stability counter cleared.
  - QUAL: eligible; counter counts cycles p unchanged.
  - HELD: commit or error done; waits for p to change.
- Transitions:
  - Any cycle p differs from previous p: counter=1; go QUAL if eligible, else IDLE. This applies in every state.
  - QUAL with p unchanged: counter+1. Reaching STABLE_CYC triggers commit/error and goes HELD.
  - HELD: no further action until p changes. Exactly one commit per stable episode.
- Commit, valid code:
  - val_o digit k <= nibble; dig_valid_o[k] <= 1.
  - upd_idx_o <= k, upd_val_o <= nibble, upd_o pulses.
  - Pulses on every qualified scan, even if the value is unchanged.
- Invalid code:
  - err_o pulses; upd_idx_o <= k; err_cnt_o increments, saturating at 255.
  - val_o, dig_valid_o and upd_val_o are unchanged.
- Digit index k = position of the single 0 bit in dig.
- Multiple or zero digit selects low: IDLE, no error.

## Timing
- Reset (asynchronous, immediate):
  - All outputs 0: val_o, dig_valid_o, upd_o, upd_idx_o, upd_val_o, err_o, err_cnt_o.
  - p = {blank, all-ones}; counter 0; state IDLE.
- Latency: input held stable from cycle c is registered in cycle c+1. Commit outputs appear in cycle c+1+STABLE_CYC, as registered outputs.
  - STABLE_CYC=4: input applied cycle 0 → upd_o high in cycle 5.
- Minimum hold: the input must be constant for STABLE_CYC cycles; a change at cycle c+STABLE_CYC-1 or earlier aborts the commit.
- upd_o and err_o are exactly one cycle wide and are never high together.
- Reset asserted mid-QUAL: pending commit discarded. After release, qualification restarts from the first registered sample.
- STABLE_CYC=1: commit in the cycle after the first registered eligible sample.

## Test plan
- Reset then hold dig_i=1110, seg_i=0100100 for 6 cycles → upd_o single pulse in cycle 5, upd_idx_o=0, upd_val_o=2, val_o[3:0]=2, dig_valid_o=0001.
- Scan digits 0..3 with codes for A,b,C,d, 5 cycles each → four upd_o pulses with idx 0..3; val_o=16'hDCBA; dig_valid_o=1111.
- Hold dig_i=1101 with seg_i=0000000 for 3 cycles, then change → no upd_o; val_o unchanged.
- dig_i=0111, seg_i=1010101 held 5 cycles → err_o one pulse, upd_idx_o=3, err_cnt_o=1, val_o unchanged. Repeat 300 episodes → err_cnt_o=255.
- dig_i=1100 or 1111 with valid codes, and dig_i=1110 with seg_i=1111111 → no upd_o, no err_o.
- Assert rst_i asynchronously in cycle 3 of a qualifying episode → all outputs 0 immediately. After release, the commit occurs STABLE_CYC+1 cycles after release; no earlier pulse.

Source files
------------

// File: rtl/seg_scan_reader.sv
// seg_scan_reader: reads back hex digits from a multiplexed active-low
// 7-segment bus. Each {seg, dig} pattern must be stable for STABLE_CYC
// registered samples before it is decoded and committed to its digit slot.
module seg_scan_reader #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4,
    localparam int IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [6:0]          seg_i,
    input  logic [DIGITS-1:0]   dig_i,
    output logic [4*DIGITS-1:0] val_o,
    output logic [DIGITS-1:0]   dig_valid_o,
    output logic                upd_o,
    output logic [IW-1:0]       upd_idx_o,
    output logic [3:0]          upd_val_o,
    output logic                err_o,
    output logic [7:0]          err_cnt_o
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int PW = 7 + DIGITS;
    localparam logic [PW-1:0] P_RST = {7'h7f, {DIGITS{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_QUAL, S_HELD} state_t;

    logic [PW-1:0]       r_p, r_p_prev;
    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [4*DIGITS-1:0] r_val;
    logic [DIGITS-1:0]   r_dig_valid;
    logic                r_upd, r_err;
    logic [IW-1:0]       r_upd_idx;
    logic [3:0]          r_upd_val;
    logic [7:0]          r_err_cnt;

    logic [6:0]          w_seg;
    logic [DIGITS-1:0]   w_sel;
    logic                w_onehot, w_blank, w_elig, w_changed, w_fire;
    logic [IW-1:0]       w_idx;
    logic                w_dec_ok;
    logic [3:0]          w_dec_val;
    logic [CW-1:0]       w_cnt_nxt;

    assign w_seg     = r_p[PW-1 -: 7];
    assign w_sel     = ~r_p[DIGITS-1:0];
    assign w_onehot  = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
    assign w_blank   = (w_seg == 7'h7f);
    assign w_elig    = w_onehot && !w_blank;
    assign w_changed = (r_p != r_p_prev);
    // A change always restarts the count at 1 (this sample is the first stable one)
    assign w_cnt_nxt = w_changed ? CW'(1) : r_cnt + CW'(1);
    // Fire once per episode: on the sample that brings the count to STABLE_CYC
    assign w_fire    = w_elig && (w_changed || r_state == S_QUAL) &&
                       (w_cnt_nxt == CW'(STABLE_CYC));

    // Position of the (single) low digit select
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < DIGITS; i++)
            if (w_sel[i]) w_idx = IW'(i);
    end

    // Segment pattern (g..a, 0 = lit) back to a nibble
    always_comb begin
        w_dec_ok  = 1'b1;
        w_dec_val = 4'h0;
        case (w_seg)
            7'b1000000: w_dec_val = 4'h0;
            7'b1111001: w_dec_val = 4'h1;
            7'b0100100: w_dec_val = 4'h2;
            7'b0110000: w_dec_val = 4'h3;
            7'b0011001: w_dec_val = 4'h4;
            7'b0010010: w_dec_val = 4'h5;
            7'b0000010: w_dec_val = 4'h6;
            7'b1111000: w_dec_val = 4'h7;
            7'b0000000: w_dec_val = 4'h8;
            7'b0010000: w_dec_val = 4'h9;
            7'b0001000: w_dec_val = 4'hA;
            7'b0000011: w_dec_val = 4'hB;
            7'b1000110: w_dec_val = 4'hC;
            7'b0100001: w_dec_val = 4'hD;
            7'b0000110: w_dec_val = 4'hE;
            7'b0001110: w_dec_val = 4'hF;
            default:    w_dec_ok  = 1'b0;
        endcase
    end

    // Input stage: sample the bus and keep the previous sample for change detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_p      <= P_RST;
            r_p_prev <= P_RST;
        end else begin
            r_p      <= {seg_i, dig_i};
            r_p_prev <= r_p;
        end
    end

    // Qualification FSM with registered commit/error outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_val       <= '0;
            r_dig_valid <= '0;
            r_upd       <= 1'b0;
            r_err       <= 1'b0;
            r_upd_idx   <= '0;
            r_upd_val   <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_upd <= 1'b0;
            r_err <= 1'b0;
            if (w_changed) begin
                r_cnt   <= CW'(1);
                r_state <= w_elig ? S_QUAL : S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE:  r_cnt <= '0;
                    S_QUAL:  r_cnt <= w_cnt_nxt;
                    default: ;
                endcase
            end
            if (w_fire) begin
                r_state   <= S_HELD;
                r_upd_idx <= w_idx;
                if (w_dec_ok) begin
                    r_val[w_idx*4 +: 4] <= w_dec_val;
                    r_dig_valid[w_idx]  <= 1'b1;
                    r_upd_val           <= w_dec_val;
                    r_upd               <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                    if (r_err_cnt != 8'hff) r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    assign val_o       = r_val;
    assign dig_valid_o = r_dig_valid;
    assign upd_o       = r_upd;
    assign upd_idx_o   = r_upd_idx;
    assign upd_val_o   = r_upd_val;
    assign err_o       = r_err;
    assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Bench for seg_scan_reader: directed steps; expected upd/err events are
// queued when stimulus is applied and matched by a monitor on the falling edge.
module tb_seg_scan_reader;

    localparam int DIGITS = 4;
    localparam int SC     = 4;
    localparam int IW     = 2;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [6:0]          seg_i;
    logic [DIGITS-1:0]   dig_i;
    logic [4*DIGITS-1:0] val_o;
    logic [DIGITS-1:0]   dig_valid_o;
    logic                upd_o;
    logic [IW-1:0]       upd_idx_o;
    logic [3:0]          upd_val_o;
    logic                err_o;
    logic [7:0]          err_cnt_o;

    seg_scan_reader #(.DIGITS(DIGITS), .STABLE_CYC(SC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .seg_i(seg_i), .dig_i(dig_i),
        .val_o(val_o), .dig_valid_o(dig_valid_o), .upd_o(upd_o),
        .upd_idx_o(upd_idx_o), .upd_val_o(upd_val_o), .err_o(err_o),
        .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit is_err;
        int idx;
        int val;
        int cyc;
    } ev_t;

    ev_t sb[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    localparam logic [6:0] BLANK = 7'h7f;
    logic [6:0] enc [16];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (upd_o && err_o) chk("upd_err_overlap", 1, 0);
            if (upd_o || err_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 32'(cyc), 0);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    chk("ev_kind", 32'(err_o), 32'(e.is_err));
                    chk("ev_idx",  32'(upd_idx_o), 32'(e.idx));
                    chk("ev_cyc",  32'(cyc), 32'(e.cyc));
                    if (!e.is_err) chk("ev_val", 32'(upd_val_o), 32'(e.val));
                end
            end
        end
    end

    task automatic drive(input logic [DIGITS-1:0] d, input logic [6:0] s, input int n);
        dig_i = d;
        seg_i = s;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic expect_ev(input bit is_err, input int idx, input int val);
        ev_t e;
        e.is_err = is_err;
        e.idx    = idx;
        e.val    = val;
        e.cyc    = cyc + SC + 1;
        sb.push_back(e);
    endtask

    initial begin
        int exp_cnt;
        int rel;
        enc = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        rst_i = 1'b1;
        dig_i = '1;
        seg_i = BLANK;
        repeat (2) @(negedge clk_i);
        chk("rst_val",   32'(val_o), 0);
        chk("rst_dv",    32'(dig_valid_o), 0);
        chk("rst_upd",   32'(upd_o), 0);
        chk("rst_idx",   32'(upd_idx_o), 0);
        chk("rst_uval",  32'(upd_val_o), 0);
        chk("rst_err",   32'(err_o), 0);
        chk("rst_ecnt",  32'(err_cnt_o), 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Single digit, code 2
        expect_ev(0, 0, 2);
        drive(4'b1110, enc[2], 6);
        drive(4'b1111, BLANK, 2);
        chk("t1_val", 32'(val_o[3:0]), 2);
        chk("t1_dv",  32'(dig_valid_o), 4'b0001);

        // Scan A,b,C,d on digits 0..3
        for (int k = 0; k < 4; k++) begin
            logic [3:0] d;
            d = 4'hf;
            d[k] = 1'b0;
            expect_ev(0, k, 10 + k);
            drive(d, enc[10 + k], 5);
        end
        drive(4'b1111, BLANK, 3);
        chk("t2_val", 32'(val_o), 16'hDCBA);
        chk("t2_dv",  32'(dig_valid_o), 4'b1111);

        // Too short a hold: no commit
        drive(4'b1101, enc[8], 3);
        drive(4'b1111, BLANK, 6);
        chk("t3_val", 32'(val_o), 16'hDCBA);
        chk("t3_sb",  32'(sb.size()), 0);

        // Undecodable pattern on digit 3
        expect_ev(1, 3, 0);
        drive(4'b0111, 7'b1010101, 5);
        drive(4'b1111, BLANK, 2);
        chk("t4_ecnt", 32'(err_cnt_o), 1);
        chk("t4_idx",  32'(upd_idx_o), 3);
        chk("t4_val",  32'(val_o), 16'hDCBA);
        chk("t4_uval", 32'(upd_val_o), 4'hD);
        chk("t4_dv",   32'(dig_valid_o), 4'b1111);
        exp_cnt = 1;
        for (int r = 1; r < 300; r++) begin
            expect_ev(1, 3, 0);
            drive(4'b0111, 7'b1010101, 5);
            drive(4'b1111, BLANK, 1);
            if (exp_cnt < 255) exp_cnt++;
        end
        drive(4'b1111, BLANK, 2);
        chk("t4_sat", 32'(err_cnt_o), 32'(exp_cnt));

        // Ineligible patterns: two selects, no select, blank segments
        drive(4'b1100, enc[5], 6);
        drive(4'b1111, enc[7], 6);
        drive(4'b1110, BLANK, 6);
        drive(4'b1111, BLANK, 2);
        chk("t5_sb",  32'(sb.size()), 0);
        chk("t5_val", 32'(val_o), 16'hDCBA);

        // Async reset mid-qualification, then commit after release
        drive(4'b1110, enc[1], 2);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("t6_val",  32'(val_o), 0);
        chk("t6_dv",   32'(dig_valid_o), 0);
        chk("t6_ecnt", 32'(err_cnt_o), 0);
        chk("t6_idx",  32'(upd_idx_o), 0);
        chk("t6_uval", 32'(upd_val_o), 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        rel = cyc;
        expect_ev(0, 0, 1);
        repeat (SC + 3) @(negedge clk_i);
        chk("t6_rel_cyc", 32'(rel + SC + 1), 32'(sb.size() == 0 ? rel + SC + 1 : -1));
        chk("t6_val2", 32'(val_o), 16'h0001);
        chk("t6_dv2",  32'(dig_valid_o), 4'b0001);

        drive(4'b1111, BLANK, 3);
        chk("final_sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
